// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, issues single-cycle-latency reads to
// instruction memory, and queues returned words for decode behind a valid/ready port.
module fetch_unit #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DEPTH         = 2,
  parameter int RESET_PC      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_i,
  output logic                     imem_en_o,
  output logic [ADDRESS_WIDTH:0]   imem_addr_o,
  input  logic [31:0]              imem_rdata_i,
  output logic                     inst_valid_o,
  input  logic                     inst_ready_i,
  output logic [31:0]              inst_word_o,
  output logic [ADDRESS_WIDTH:0]   inst_pc_o,
  input  logic                     redirect_valid_i,
  input  logic [ADDRESS_WIDTH:0]   redirect_pc_i,
  output logic                     dbg_state_o
);

  localparam int PCW = ADDRESS_WIDTH + 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Handshake: the head word moves to decode on any rising edge where
  // inst_valid_o and inst_ready_i are both high; word/pc hold while stalled.
  state_e           state_q, state_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic             infl_q, infl_d;
  logic [PCW-1:0]   infl_pc_q, infl_pc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [31:0]      word_q [DEPTH];
  logic [31:0]      word_d [DEPTH];
  logic [PCW-1:0]   tag_q  [DEPTH];
  logic [PCW-1:0]   tag_d  [DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic [CW:0]      occ;
  logic [IW-1:0]    wr_idx;

  always_comb begin
    pop    = (count_q != '0) && inst_ready_i;
    push   = infl_q && !redirect_valid_i;
    // Credit counts the read still in flight so a returning word always has a slot.
    occ    = (CW+1)'(count_q) + (CW+1)'(infl_q) - (CW+1)'(pop);
    issue  = (state_q == RUN) && enable_i && !redirect_valid_i && (occ < (CW+1)'(DEPTH));
    wr_idx = IW'(count_q - CW'(pop));

    state_d = enable_i ? RUN : IDLE;

    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
    end else if (issue) begin
      pc_d = pc_q + 1'b1;
    end

    infl_d    = issue;
    infl_pc_d = pc_q;

    word_d = word_q;
    tag_d  = tag_q;
    // Shift only when another entry remains, so an emptied buffer keeps showing
    // its last head; a flush likewise leaves the entries in place.
    if (pop && !redirect_valid_i && (count_q > CW'(1))) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        word_d[i] = word_q[i+1];
        tag_d[i]  = tag_q[i+1];
      end
    end
    if (push) begin
      word_d[wr_idx] = imem_rdata_i;
      tag_d[wr_idx]  = infl_pc_q;
    end

    if (redirect_valid_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= PCW'(RESET_PC);
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
      count_q   <= count_d;
      word_q    <= word_d;
      tag_q     <= tag_d;
    end
  end

  assign imem_en_o    = issue;
  assign imem_addr_o  = pc_q;
  assign inst_valid_o = (count_q != '0);
  assign inst_word_o  = word_q[0];
  assign inst_pc_o    = tag_q[0];
  assign dbg_state_o  = state_q;

endmodule
